wrr_burst_arbiter: RTL and testbench

Weighted round-robin arbiter with burst hold. It shares one resource between N requesters. The current owner keeps the grant for up to its programmed weight in consecutive cycles, then priority rotates to the next requester. It sits in front of the shared bus/resource beside the plain round-robin arbiter and replaces it where requesters need multi-cycle bursts. All outputs are registered.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/rr_priority_pick.sv | 40 ++++
 rtl/wrr_burst_arbiter.sv | 110 +++++++++++
 tb/tb_wrr_burst_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the weighted round-robin burst arbiter.
package arb_pkg;

  localparam int N_DEF  = 4;
  localparam int WW_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Next index in the rotation, wrapping back to 0 after n-1.
  function automatic int wrap_inc(input int idx, input int n = N_DEF);
    if (idx + 1 >= n) begin
      return 0;
    end else begin
      return idx + 1;
    end
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority first-one picker: lowest set bit of req at or after base.
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic          found,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;

  // Double-width copy shifted by base puts requester base at bit 0.
  assign dbl_s = {req, req} >> base;
  assign rot_s = dbl_s[N-1:0];

  // Scan high to low so the lowest rotated position is the final winner.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        found = 1'b1;
        idx   = IW'((int'(base) + i) % N);
      end else begin
        found = found;
      end
    end
    if (found) begin
      onehot = N'(1) << idx;
    end else begin
      onehot = '0;
    end
  end

endmodule

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter: owner holds the grant for up to its weight
// in consecutive cycles, then priority rotates past it. Outputs registered.
module wrr_burst_arbiter
  import arb_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int WW = WW_DEF,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N*WW-1:0] weight,
  output logic [N-1:0]    grant,
  output logic [IW-1:0]   grant_id,
  output logic            grant_valid,
  output logic            grant_last
);

  state_t        state_r, state_nxt_s;
  logic [IW-1:0] owner_r, owner_nxt_s;
  logic [WW-1:0] cnt_r, cnt_nxt_s;
  logic [IW-1:0] ptr_r, ptr_nxt_s;

  logic [IW-1:0] pick_base_s;
  logic          pick_found_s;
  logic [IW-1:0] pick_idx_s;
  logic [N-1:0]  pick_onehot_s;
  logic [WW-1:0] pick_weight_s;
  logic [WW-1:0] pick_load_s;
  logic          hold_s;

  // In GRANT the scan starts just past the current owner; in IDLE at ptr.
  assign pick_base_s = (state_r == GRANT) ? IW'(wrap_inc(int'(owner_r), N)) : ptr_r;

  rr_priority_pick #(.N(N), .IW(IW)) u_pick (
    .req    (req),
    .base   (pick_base_s),
    .found  (pick_found_s),
    .idx    (pick_idx_s),
    .onehot (pick_onehot_s)
  );

  // A zero weight still gives the winner one cycle of grant.
  assign pick_weight_s = weight[pick_idx_s*WW +: WW];
  assign pick_load_s   = (pick_weight_s == '0) ? WW'(1) : pick_weight_s;
  assign hold_s        = req[owner_r] && (cnt_r > WW'(1));

  // Next-state logic: hold, hand off with no bubble, or fall back to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    owner_nxt_s = owner_r;
    cnt_nxt_s   = cnt_r;
    ptr_nxt_s   = ptr_r;
    case (state_r)
      IDLE: begin
        if (pick_found_s) begin
          state_nxt_s = GRANT;
          owner_nxt_s = pick_idx_s;
          cnt_nxt_s   = pick_load_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        if (hold_s) begin
          cnt_nxt_s = cnt_r - WW'(1);
        end else begin
          ptr_nxt_s = pick_base_s;
          if (pick_found_s) begin
            state_nxt_s = GRANT;
            owner_nxt_s = pick_idx_s;
            cnt_nxt_s   = pick_load_s;
          end else begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = '0;
          end
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // State, bookkeeping and output registers; outputs mirror the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      owner_r     <= '0;
      cnt_r       <= '0;
      ptr_r       <= '0;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      grant_last  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      owner_r     <= owner_nxt_s;
      cnt_r       <= cnt_nxt_s;
      ptr_r       <= ptr_nxt_s;
      grant       <= (state_nxt_s == GRANT) ? (N'(1) << owner_nxt_s) : '0;
      grant_id    <= (state_nxt_s == GRANT) ? owner_nxt_s : '0;
      grant_valid <= (state_nxt_s == GRANT);
      grant_last  <= (state_nxt_s == GRANT) && (cnt_nxt_s == WW'(1));
    end
  end

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Directed bench for wrr_burst_arbiter with N=4, WW=4.
module tb_wrr_burst_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] weight;
  logic [3:0]  grant;
  logic [1:0]  grant_id;
  logic        grant_valid;
  logic        grant_last;

  int n_checks;
  int n_errors;

  wrr_burst_arbiter #(.N(4), .WW(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .weight      (weight),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .grant_last  (grant_last)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then compare every output against the expectation.
  task automatic step_expect(input string tag, input logic [3:0] g, input logic [1:0] id,
                             input logic last);
    @(posedge clk);
    #1;
    check_val({tag, ".grant"}, 32'(grant), 32'(g));
    check_val({tag, ".id"},    32'(grant_id), 32'(id));
    check_val({tag, ".valid"}, 32'(grant_valid), 32'(g != 4'b0000));
    check_val({tag, ".last"},  32'(grant_last), 32'(last));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    req      = 4'b1111;
    weight   = 16'h1111;
    #1;

    // Reset held two cycles with all requests up.
    step_expect("rst0", 4'b0000, 2'd0, 1'b0);
    step_expect("rst1", 4'b0000, 2'd0, 1'b0);
    reset = 1'b0;
    step_expect("post_rst0", 4'b0001, 2'd0, 1'b1);
    step_expect("post_rst1", 4'b0010, 2'd1, 1'b1);

    // Single requester 2 with weight 3: continuous grant, last every 3rd.
    do_reset();
    weight = 16'h0300;
    req    = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      step_expect($sformatf("solo%0d", k), 4'b0100, 2'd2, (k % 3) == 2);
    end

    // Requesters 0 and 2, weight 2 each: pairs alternate.
    do_reset();
    weight = 16'h2222;
    req    = 4'b0101;
    for (int k = 0; k < 8; k++) begin
      step_expect($sformatf("pair%0d", k), ((k / 2) % 2 == 0) ? 4'b0001 : 4'b0100,
                  ((k / 2) % 2 == 0) ? 2'd0 : 2'd2, (k % 2) == 1);
    end

    // Owner 0 (weight 4) drops after one cycle: immediate hand-off to 3.
    do_reset();
    weight = 16'h0004;
    req    = 4'b1001;
    step_expect("drop0", 4'b0001, 2'd0, 1'b0);
    req = 4'b1000;
    step_expect("drop1", 4'b1000, 2'd3, 1'b1);
    step_expect("drop2", 4'b1000, 2'd3, 1'b1);
    req = 4'b0000;
    step_expect("drop_idle", 4'b0000, 2'd0, 1'b0);

    // All weights zero: one-cycle bursts rotating through everyone.
    do_reset();
    weight = 16'h0000;
    req    = 4'b1111;
    step_expect("rot0", 4'b0001, 2'd0, 1'b1);
    step_expect("rot1", 4'b0010, 2'd1, 1'b1);
    step_expect("rot2", 4'b0100, 2'd2, 1'b1);
    step_expect("rot3", 4'b1000, 2'd3, 1'b1);
    step_expect("rot4", 4'b0001, 2'd0, 1'b1);

    // Reset in the middle of owner 2's burst, then restart at requester 0.
    do_reset();
    weight = 16'h0300;
    req    = 4'b0100;
    step_expect("mid0", 4'b0100, 2'd2, 1'b0);
    req    = 4'b1111;
    reset  = 1'b1;
    step_expect("mid_rst", 4'b0000, 2'd0, 1'b0);
    reset  = 1'b0;
    weight = 16'h1111;
    step_expect("mid_restart", 4'b0001, 2'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
